// File: rtl/z16_boot_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the Z16 boot loader.
// The slave modport is the loader's view; the master modport is the byte source and memory side.
interface z16_boot_loader_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_we;
  logic [15:0] o_addr;
  logic [15:0] o_data;

  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_rx_ready, o_we, o_addr, o_data
  );

  modport master (
    output i_rx_data, i_rx_valid,
    input  o_rx_ready, o_we, o_addr, o_data
  );
endinterface

// File: rtl/z16_boot_loader.sv
// Loads a framed, checksummed byte image into Z16 instruction memory as little-endian words
// and keeps the CPU in reset until a complete image has been verified.
module z16_boot_loader #(
  parameter logic [15:0] P_BASE_ADDR = 16'h0000,
  parameter logic [7:0]  P_SYNC      = 8'h5A,
  parameter logic [15:0] P_MAX_WORDS = 16'd32768
) (
  input  logic             i_clk,
  input  logic             i_rst,
  z16_boot_loader_if.slave bus,
  output logic             o_cpu_rst,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      r_state, w_stateNext;
  logic        r_we, w_weNext;
  logic [15:0] r_addr, w_addrNext;
  logic [15:0] r_data, w_dataNext;
  logic        r_cpuRst, w_cpuRstNext;
  logic        r_done, w_doneNext;
  logic        r_err, w_errNext;
  logic [7:0]  r_lenLo, w_lenLoNext;
  logic [15:0] r_count, w_countNext;
  logic [7:0]  r_lowByte, w_lowByteNext;
  logic [7:0]  r_sum, w_sumNext;
  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_lenFull;

  assign w_ready   = (r_state != S_WRITE);
  assign w_accept  = bus.i_rx_valid && w_ready;
  assign w_lenFull = {bus.i_rx_data, r_lenLo};

  assign bus.o_rx_ready = w_ready;
  assign bus.o_we       = r_we;
  assign bus.o_addr     = r_addr;
  assign bus.o_data     = r_data;
  assign o_cpu_rst      = r_cpuRst;
  assign o_done         = r_done;
  assign o_err          = r_err;

  always_comb begin
    w_stateNext   = r_state;
    w_weNext      = 1'b0;
    w_addrNext    = r_addr;
    w_dataNext    = r_data;
    w_cpuRstNext  = r_cpuRst;
    w_doneNext    = r_done;
    w_errNext     = r_err;
    w_lenLoNext   = r_lenLo;
    w_countNext   = r_count;
    w_lowByteNext = r_lowByte;
    w_sumNext     = r_sum;
    case (r_state)
      // Idle and both terminal states hunt for a sync byte and discard everything else.
      S_IDLE, S_DONE, S_ERR: begin
        if (w_accept && bus.i_rx_data == P_SYNC) begin
          w_cpuRstNext = 1'b1;
          w_doneNext   = 1'b0;
          w_errNext    = 1'b0;
          w_addrNext   = P_BASE_ADDR;
          w_sumNext    = 8'h00;
          w_stateNext  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          w_lenLoNext = bus.i_rx_data;
          w_stateNext = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_accept) begin
          w_countNext = w_lenFull;
          if (w_lenFull == 16'd0) begin
            w_stateNext = S_CSUM;
          end else if (w_lenFull > P_MAX_WORDS) begin
            w_errNext   = 1'b1;
            w_stateNext = S_ERR;
          end else begin
            w_stateNext = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (w_accept) begin
          w_lowByteNext = bus.i_rx_data;
          w_sumNext     = r_sum + bus.i_rx_data;
          w_stateNext   = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (w_accept) begin
          w_dataNext  = {bus.i_rx_data, r_lowByte};
          w_sumNext   = r_sum + bus.i_rx_data;
          w_weNext    = 1'b1;
          w_stateNext = S_WRITE;
        end
      end
      // The strobe is high for exactly this cycle; the address advance lands after it.
      S_WRITE: begin
        w_addrNext  = r_addr + 16'd2;
        w_countNext = r_count - 16'd1;
        w_stateNext = (r_count == 16'd1) ? S_CSUM : S_DATA_LO;
      end
      S_CSUM: begin
        if (w_accept) begin
          if (bus.i_rx_data == r_sum) begin
            w_doneNext   = 1'b1;
            w_cpuRstNext = 1'b0;
            w_stateNext  = S_DONE;
          end else begin
            w_errNext   = 1'b1;
            w_stateNext = S_ERR;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_addr    <= P_BASE_ADDR;
      r_data    <= 16'h0000;
      r_cpuRst  <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_lenLo   <= 8'h00;
      r_count   <= 16'h0000;
      r_lowByte <= 8'h00;
      r_sum     <= 8'h00;
    end else begin
      r_state   <= w_stateNext;
      r_we      <= w_weNext;
      r_addr    <= w_addrNext;
      r_data    <= w_dataNext;
      r_cpuRst  <= w_cpuRstNext;
      r_done    <= w_doneNext;
      r_err     <= w_errNext;
      r_lenLo   <= w_lenLoNext;
      r_count   <= w_countNext;
      r_lowByte <= w_lowByteNext;
      r_sum     <= w_sumNext;
    end
  end

endmodule

// File: tb/tb_z16_boot_loader.sv
// Self-checking bench for z16_boot_loader: two instances (base 0x0000 and 0xFFFC) see the
// same byte stream; results are compared with constant vectors and a frame-level model.
module tb_z16_boot_loader;
  localparam logic [7:0] SYNC      = 8'h5A;
  localparam int         MAX_WORDS = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] rxData;
  logic       rxValid;
  logic       cpuRstA, doneA, errA, cpuRstB, doneB, errB;

  z16_boot_loader_if busA ();
  z16_boot_loader_if busB ();

  assign busA.i_rx_data  = rxData;
  assign busA.i_rx_valid = rxValid;
  assign busB.i_rx_data  = rxData;
  assign busB.i_rx_valid = rxValid;

  z16_boot_loader #(.P_BASE_ADDR(16'h0000)) dutA (
    .i_clk(clk), .i_rst(rst), .bus(busA),
    .o_cpu_rst(cpuRstA), .o_done(doneA), .o_err(errA)
  );

  z16_boot_loader #(.P_BASE_ADDR(16'hFFFC)) dutB (
    .i_clk(clk), .i_rst(rst), .bus(busB),
    .o_cpu_rst(cpuRstB), .o_done(doneB), .o_err(errB)
  );

  int errors = 0;
  int checks = 0;
  bit monOn  = 1'b0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wrA[$];
  wr_t         wrB[$];
  logic [7:0]  stream[$];
  logic [15:0] expData[$];
  logic        expDone, expErr, expCpuRst;

  typedef struct {
    string          name;
    logic [0:11][7:0] bytes;
    int             nBytes;
    int             nWrites;
    logic [15:0]    data0;
    logic [15:0]    data1;
    logic           done;
    logic           err;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Collect every write strobe and check that the loader only refuses bytes while writing.
  always @(negedge clk) begin
    if (monOn) begin
      if (busA.o_we === 1'b1) wrA.push_back({busA.o_addr, busA.o_data});
      if (busB.o_we === 1'b1) wrB.push_back({busB.o_addr, busB.o_data});
      checkOutput("readyVsWeA", {31'd0, busA.o_rx_ready}, {31'd0, !busA.o_we});
      checkOutput("readyVsWeB", {31'd0, busB.o_rx_ready}, {31'd0, !busB.o_we});
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    int t = 0;
    rxValid = 1'b0;
    repeat (gap) @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    while (busA.o_rx_ready !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (t == 8) checkOutput("readyTimeout", {31'd0, busA.o_rx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic sendStream(input int gapMax);
    foreach (stream[i]) sendByte(stream[i], gapMax);
  endtask

  // Frame-level reference: scan for sync, then length, words, checksum.
  task automatic modelStream();
    int p = 0;
    int len;
    logic [7:0] sum;
    expDone   = 1'b0;
    expErr    = 1'b0;
    expCpuRst = 1'b1;
    while (p < stream.size()) begin
      if (stream[p] != SYNC) begin
        p++;
        continue;
      end
      expDone   = 1'b0;
      expErr    = 1'b0;
      expCpuRst = 1'b1;
      len = int'(stream[p+1]) + 256 * int'(stream[p+2]);
      p += 3;
      if (len > MAX_WORDS) begin
        expErr = 1'b1;
        continue;
      end
      sum = 8'h00;
      for (int w = 0; w < len; w++) begin
        expData.push_back({stream[p+1], stream[p]});
        sum = sum + stream[p] + stream[p+1];
        p += 2;
      end
      if (stream[p] == sum) begin
        expDone   = 1'b1;
        expCpuRst = 1'b0;
      end else begin
        expErr = 1'b1;
      end
      p++;
    end
  endtask

  task automatic checkAll(input string tag);
    logic [15:0] addrA, addrB;
    checkOutput({tag, ".nWritesA"}, wrA.size(), expData.size());
    checkOutput({tag, ".nWritesB"}, wrB.size(), expData.size());
    for (int i = 0; i < expData.size(); i++) begin
      addrA = 16'h0000 + 16'(2 * i);
      addrB = 16'hFFFC + 16'(2 * i);
      if (i < wrA.size()) begin
        checkOutput({tag, ".addrA"}, wrA[i].addr, addrA);
        checkOutput({tag, ".dataA"}, wrA[i].data, expData[i]);
      end
      if (i < wrB.size()) begin
        checkOutput({tag, ".addrB"}, wrB[i].addr, addrB);
        checkOutput({tag, ".dataB"}, wrB[i].data, expData[i]);
      end
    end
    checkOutput({tag, ".doneA"}, doneA, expDone);
    checkOutput({tag, ".errA"}, errA, expErr);
    checkOutput({tag, ".cpuRstA"}, cpuRstA, expCpuRst);
    checkOutput({tag, ".doneB"}, doneB, expDone);
    checkOutput({tag, ".errB"}, errB, expErr);
    checkOutput({tag, ".cpuRstB"}, cpuRstB, expCpuRst);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".weA"}, busA.o_we, 0);
    checkOutput({tag, ".addrA"}, busA.o_addr, 16'h0000);
    checkOutput({tag, ".dataA"}, busA.o_data, 0);
    checkOutput({tag, ".readyA"}, busA.o_rx_ready, 1);
    checkOutput({tag, ".cpuRstA"}, cpuRstA, 1);
    checkOutput({tag, ".doneA"}, doneA, 0);
    checkOutput({tag, ".errA"}, errA, 0);
    checkOutput({tag, ".addrB"}, busB.o_addr, 16'hFFFC);
    checkOutput({tag, ".weB"}, busB.o_we, 0);
    checkOutput({tag, ".cpuRstB"}, cpuRstB, 1);
  endtask

  task automatic addVec(input string name, input logic [95:0] bytes, input int n, input int nw,
                        input logic [15:0] d0, input logic [15:0] d1, input logic done,
                        input logic err);
    vec_t v;
    v.name    = name;
    v.bytes   = bytes;
    v.nBytes  = n;
    v.nWrites = nw;
    v.data0   = d0;
    v.data1   = d1;
    v.done    = done;
    v.err     = err;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    wrA.delete();
    wrB.delete();
    stream.delete();
    for (int i = 0; i < v.nBytes; i++) stream.push_back(v.bytes[i]);
    sendStream(0);
    expData.delete();
    if (v.nWrites > 0) expData.push_back(v.data0);
    if (v.nWrites > 1) expData.push_back(v.data1);
    expDone   = v.done;
    expErr    = v.err;
    expCpuRst = !v.done;
    checkAll(v.name);
  endtask

  initial begin
    logic [7:0] sum;
    int len;
    rst     = 1'b1;
    rxValid = 1'b0;
    rxData  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst   = 1'b0;
    monOn = 1'b1;

    // 0x34+0x12+0xCD+0xAB = 0x1BE, so the good checksum byte is 0xBE.
    addVec("good2",   {8'h5A, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hBE, 32'h0}, 8, 2,
           16'h1234, 16'hABCD, 1'b1, 1'b0);
    addVec("badCsum", {8'h5A, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hBF, 32'h0}, 8, 2,
           16'h1234, 16'hABCD, 1'b0, 1'b1);
    addVec("recover", {8'h5A, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hBE, 32'h0}, 8, 2,
           16'h1234, 16'hABCD, 1'b1, 1'b0);
    addVec("garbageEmpty", {8'h00, 8'hFF, 8'h11, 8'h5A, 8'h00, 8'h00, 8'h00, 40'h0}, 7, 0,
           16'h0, 16'h0, 1'b1, 1'b0);
    addVec("tooLong", {8'h5A, 8'h01, 8'h80, 72'h0}, 3, 0, 16'h0, 16'h0, 1'b0, 1'b1);
    addVec("syncAsData", {8'h5A, 8'h01, 8'h00, 8'h5A, 8'h5A, 8'hB4, 48'h0}, 6, 1,
           16'h5A5A, 16'h0, 1'b1, 1'b0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      if (vecs[k].name == "tooLong") checkOutput("tooLong.ready", busA.o_rx_ready, 1);
    end

    // Largest legal length is accepted; reset after the third data byte abandons the frame.
    wrA.delete();
    wrB.delete();
    stream = '{8'h5A, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33};
    sendStream(0);
    checkOutput("maxLen.errA", errA, 0);
    checkOutput("maxLen.nWritesA", wrA.size(), 1);
    if (wrA.size() > 0) checkOutput("maxLen.dataA", wrA[0].data, 16'h2211);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkReset("midReset");
    rst = 1'b0;
    wrA.delete();
    wrB.delete();
    repeat (10) @(negedge clk);
    checkOutput("midReset.noWrites", wrA.size(), 0);

    stream = '{8'h5A, 8'h01, 8'h00, 8'h78, 8'h56, 8'hCE};
    expData.delete();
    sendStream(1);
    modelStream();
    checkAll("afterReset");

    // Random frames with garbage prefixes, valid gaps and occasional bad checksums.
    for (int it = 0; it < 25; it++) begin
      stream.delete();
      expData.delete();
      wrA.delete();
      wrB.delete();
      repeat ($urandom_range(3, 0)) begin
        logic [7:0] g = 8'($urandom_range(255, 0));
        stream.push_back((g == SYNC) ? 8'h00 : g);
      end
      len = (it == 0) ? 4 : int'($urandom_range(5, 0));
      stream.push_back(SYNC);
      stream.push_back(8'(len));
      stream.push_back(8'h00);
      sum = 8'h00;
      for (int b = 0; b < 2 * len; b++) begin
        logic [7:0] d = 8'($urandom_range(255, 0));
        stream.push_back(d);
        sum = sum + d;
      end
      stream.push_back(($urandom_range(3, 0) == 0) ? sum + 8'h01 : sum);
      sendStream(3);
      modelStream();
      checkAll($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
